// File: rtl/muldiv_sequencer_pkg.sv
// Shared funct codes, FSM state encoding and opcode decode helpers for the
// HI/LO multiply/divide sequencer.
package muldiv_sequencer_pkg;

   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_SIGN = 2'd2
   } md_state_e;

   function automatic logic is_muldiv(input logic [5:0] funct);
      return (funct == FN_MULT) || (funct == FN_MULTU) ||
             (funct == FN_DIV)  || (funct == FN_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [5:0] funct);
      return (funct == FN_MULT) || (funct == FN_DIV);
   endfunction

   function automatic logic is_div_op(input logic [5:0] funct);
      return (funct == FN_DIV) || (funct == FN_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_sequencer_sign_adjust.sv
// Combinational conditional two's-complement negate; used for operand
// magnitudes and for the final product/quotient/remainder sign fix-up.
module muldiv_sign_adjust #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             neg_i,
   input  logic [WIDTH-1:0] val_i,
   output logic [WIDTH-1:0] res_o
);

   always_comb begin
      res_o = val_i;
      if (neg_i) begin
         res_o = ~val_i + WIDTH'(1);
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// MIPS MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one bit per cycle.
// Optional macro MULDIV_EARLY_OUT_EN: multiply leaves CALC once the
// remaining multiplier-magnitude bits are all zero.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             w_start_1,
   input  logic [5:0]       w_op_code_6,
   input  logic [WIDTH-1:0] w_input1_x,
   input  logic [WIDTH-1:0] w_input2_x,
   input  logic             w_flush_1,
   output logic             w_busy_1,
   output logic             w_done_1,
   output logic [WIDTH-1:0] w_hi_x,
   output logic [WIDTH-1:0] w_lo_x
);

   localparam int unsigned W2 = 2 * WIDTH;
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   md_state_e        state_q, state_d;
   logic [W2-1:0]    acc_q, acc_d;      // mul: product; div: {remainder, quotient}
   logic [W2-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] opb_q, opb_d;      // mul: multiplier (shifts right); div: divisor
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             div_q, div_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic             dvz_q, dvz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;

   logic             sgn_op, neg_a, neg_b;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [W2-1:0]    prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;
   logic [WIDTH:0]   rem_sh, diff;
   logic             last_iter;

   assign sgn_op = is_signed_op(w_op_code_6);
   assign neg_a  = sgn_op & w_input1_x[WIDTH-1];
   assign neg_b  = sgn_op & w_input2_x[WIDTH-1];

   muldiv_sign_adjust #(.WIDTH(WIDTH)) u_abs_a (
      .neg_i(neg_a), .val_i(w_input1_x), .res_o(abs_a));
   muldiv_sign_adjust #(.WIDTH(WIDTH)) u_abs_b (
      .neg_i(neg_b), .val_i(w_input2_x), .res_o(abs_b));
   muldiv_sign_adjust #(.WIDTH(W2)) u_fix_prod (
      .neg_i(neg_res_q), .val_i(acc_q), .res_o(prod_fix));
   muldiv_sign_adjust #(.WIDTH(WIDTH)) u_fix_quo (
      .neg_i(neg_res_q), .val_i(acc_q[WIDTH-1:0]), .res_o(quo_fix));
   muldiv_sign_adjust #(.WIDTH(WIDTH)) u_fix_rem (
      .neg_i(neg_rem_q), .val_i(acc_q[W2-1:WIDTH]), .res_o(rem_fix));

   // Restoring step: shift the next dividend bit into the partial remainder.
   assign rem_sh = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, opb_q};

`ifdef MULDIV_EARLY_OUT_EN
   assign last_iter = (cnt_q == CW'(WIDTH - 1)) ||
                      (!div_q && (opb_q[WIDTH-1:1] == '0));
`else
   assign last_iter = (cnt_q == CW'(WIDTH - 1));
`endif

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      opb_d     = opb_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dvz_d     = dvz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;

      unique case (state_q)
         MD_IDLE: begin
            if (w_start_1 && !w_flush_1) begin
               if (is_muldiv(w_op_code_6)) begin
                  div_d     = is_div_op(w_op_code_6);
                  acc_d     = is_div_op(w_op_code_6) ? {{WIDTH{1'b0}}, abs_a} : '0;
                  mcand_d   = {{WIDTH{1'b0}}, abs_a};
                  opb_d     = abs_b;
                  neg_res_d = neg_a ^ neg_b;
                  neg_rem_d = neg_a;
                  dvz_d     = (w_input2_x == '0);
                  cnt_d     = '0;
                  state_d   = MD_CALC;
               end else if (w_op_code_6 == FN_MTHI) begin
                  hi_d = w_input1_x;
               end else if (w_op_code_6 == FN_MTLO) begin
                  lo_d = w_input1_x;
               end
            end
         end

         MD_CALC: begin
            if (div_q) begin
               if (!diff[WIDTH]) begin
                  acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc_d   = acc_q + (opb_q[0] ? mcand_q : '0);
               mcand_d = mcand_q << 1;
               opb_d   = opb_q >> 1;
            end
            cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
               cnt_d   = '0;
               state_d = MD_SIGN;
            end
            if (w_flush_1) begin
               cnt_d   = '0;
               state_d = MD_IDLE;
            end
         end

         MD_SIGN: begin
            state_d = MD_IDLE;
            if (!w_flush_1) begin
               done_d = 1'b1;
               if (div_q) begin
                  // Divide by zero: quotient all ones, remainder fix-up restores raw dividend.
                  lo_d = dvz_q ? '1 : quo_fix;
                  hi_d = rem_fix;
               end else begin
                  {hi_d, lo_d} = prod_fix;
               end
            end
         end

         default: begin
            state_d = MD_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= MD_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         opb_q     <= '0;
         cnt_q     <= '0;
         div_q     <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dvz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         opb_q     <= opb_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dvz_q     <= dvz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign w_busy_1 = (state_q != MD_IDLE);
   assign w_done_1 = done_q;
   assign w_hi_x   = hi_q;
   assign w_lo_x   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table for mul/div results and
// latency, plus hand sequences for MTHI/MTLO, flush, ignored starts and reset.
module tb_muldiv_sequencer;

   localparam logic [5:0] OP_MTHI  = 6'h11;
   localparam logic [5:0] OP_MTLO  = 6'h13;
   localparam logic [5:0] OP_MULT  = 6'h18;
   localparam logic [5:0] OP_MULTU = 6'h19;
   localparam logic [5:0] OP_DIV   = 6'h1A;
   localparam logic [5:0] OP_DIVU  = 6'h1B;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        w_start_1 = 1'b0;
   logic [5:0]  w_op_code_6 = '0;
   logic [31:0] w_input1_x = '0;
   logic [31:0] w_input2_x = '0;
   logic        w_flush_1 = 1'b0;
   logic        w_busy_1, w_done_1;
   logic [31:0] w_hi_x, w_lo_x;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   always #5 clock = ~clock;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .w_start_1  (w_start_1),
      .w_op_code_6(w_op_code_6),
      .w_input1_x (w_input1_x),
      .w_input2_x (w_input2_x),
      .w_flush_1  (w_flush_1),
      .w_busy_1   (w_busy_1),
      .w_done_1   (w_done_1),
      .w_hi_x     (w_hi_x),
      .w_lo_x     (w_lo_x)
   );

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   // Start-to-done latency: multiply iterations shrink with early-out enabled.
   function automatic int unsigned exp_lat(input logic [5:0] op, input logic [31:0] b);
      int unsigned iters;
      logic [31:0] mag;
      iters = 32;
`ifdef MULDIV_EARLY_OUT_EN
      if (op == OP_MULT || op == OP_MULTU) begin
         mag = (op == OP_MULT && b[31]) ? (~b + 32'd1) : b;
         iters = 1;
         for (int i = 1; i < 32; i++) if (mag[i]) iters = i + 1;
      end
`else
      mag = b;
      if (op == 6'h00 && mag == 32'd0) iters = 32;
`endif
      return iters + 2;
   endfunction

   // Called on a negedge; drives start in that cycle and returns on the done cycle's negedge.
   task automatic run_vec(input int idx, input vec_t v);
      int unsigned n;
      logic busy_ok;
      w_start_1   = 1'b1;
      w_op_code_6 = v.op;
      w_input1_x  = v.a;
      w_input2_x  = v.b;
      @(negedge clock);
      w_start_1   = 1'b0;
      w_op_code_6 = 6'h3F;
      w_input1_x  = $urandom;
      w_input2_x  = $urandom;
      n = 1;
      busy_ok = 1'b1;
      while (!w_done_1 && n < 100) begin
         if (!w_busy_1) busy_ok = 1'b0;
         @(negedge clock);
         n++;
      end
      chk($sformatf("v%0d_latency", idx), 64'(n), 64'(exp_lat(v.op, v.b)));
      chk($sformatf("v%0d_busy_window", idx), 64'(busy_ok), 64'd1);
      chk($sformatf("v%0d_busy_at_done", idx), 64'(w_busy_1), 64'd0);
      chk($sformatf("v%0d_hi", idx), 64'(w_hi_x), 64'(v.hi));
      chk($sformatf("v%0d_lo", idx), 64'(w_lo_x), 64'(v.lo));
   endtask

   initial begin
      logic quiet_ok;

      vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
      vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{OP_MULTU, 32'h00000005, 32'h00000003, 32'h00000000, 32'h0000000F};
      vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[8]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
      vecs[9]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
      vecs[10] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

      // Reset state
      #12;
      chk("reset_hi", 64'(w_hi_x), 64'd0);
      chk("reset_lo", 64'(w_lo_x), 64'd0);
      chk("reset_busy", 64'(w_busy_1), 64'd0);
      chk("reset_done", 64'(w_done_1), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // MTHI / MTLO
      w_start_1 = 1'b1; w_op_code_6 = OP_MTHI; w_input1_x = 32'h1234;
      @(negedge clock);
      w_start_1 = 1'b0;
      chk("mthi_hi", 64'(w_hi_x), 64'h1234);
      chk("mthi_busy", 64'(w_busy_1), 64'd0);
      chk("mthi_done", 64'(w_done_1), 64'd0);
      w_start_1 = 1'b1; w_op_code_6 = OP_MTLO; w_input1_x = 32'h5678;
      @(negedge clock);
      w_start_1 = 1'b0;
      chk("mtlo_lo", 64'(w_lo_x), 64'h5678);
      chk("mtlo_hi_kept", 64'(w_hi_x), 64'h1234);

      // Start at T, ignored start at T+5, flush at T+10
      w_start_1 = 1'b1; w_op_code_6 = OP_MULTU; w_input1_x = 32'd2; w_input2_x = 32'h80000003;
      @(negedge clock);
      w_start_1 = 1'b0;
      repeat (4) @(negedge clock);
      w_start_1 = 1'b1; w_op_code_6 = OP_DIVU; w_input1_x = 32'd99; w_input2_x = 32'd3;
      @(negedge clock);
      w_start_1 = 1'b0;
      chk("busy_mid_op", 64'(w_busy_1), 64'd1);
      repeat (4) @(negedge clock);
      w_flush_1 = 1'b1;
      @(negedge clock);
      w_flush_1 = 1'b0;
      chk("flush_busy", 64'(w_busy_1), 64'd0);
      chk("flush_hi", 64'(w_hi_x), 64'h1234);
      chk("flush_lo", 64'(w_lo_x), 64'h5678);
      quiet_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (w_busy_1 || w_done_1) quiet_ok = 1'b0;
         @(negedge clock);
      end
      chk("flush_no_done_no_queue", 64'(quiet_ok), 64'd1);

      // Flush and start together in IDLE: start dropped
      w_flush_1 = 1'b1; w_start_1 = 1'b1; w_op_code_6 = OP_MULTU;
      w_input1_x = 32'd2; w_input2_x = 32'd3;
      @(negedge clock);
      w_flush_1 = 1'b0; w_start_1 = 1'b0;
      chk("flush_start_busy", 64'(w_busy_1), 64'd0);

      // Unknown funct ignored
      w_start_1 = 1'b1; w_op_code_6 = 6'h20; w_input1_x = 32'hDEAD;
      @(negedge clock);
      w_start_1 = 1'b0;
      chk("unknown_busy", 64'(w_busy_1), 64'd0);
      chk("unknown_hi", 64'(w_hi_x), 64'h1234);
      chk("unknown_lo", 64'(w_lo_x), 64'h5678);

      // Vector table; each start lands in the previous operation's done cycle
      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);
      @(negedge clock);
      chk("done_single_pulse", 64'(w_done_1), 64'd0);

      // Asynchronous reset mid-operation
      w_start_1 = 1'b1; w_op_code_6 = OP_MULTU;
      w_input1_x = 32'hFFFFFFFF; w_input2_x = 32'hFFFFFFFF;
      @(negedge clock);
      w_start_1 = 1'b0;
      repeat (5) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_hi", 64'(w_hi_x), 64'd0);
      chk("async_reset_lo", 64'(w_lo_x), 64'd0);
      chk("async_reset_busy", 64'(w_busy_1), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("post_reset_busy", 64'(w_busy_1), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
